fwb_slave_monitor: RTL and testbench

Synthesizable Wishbone B4 pipelined-mode protocol monitor for the slave side of a bus. It sits passively beside a slave (e.g. the SRAM bridge) and observes every master request and slave response. It counts accepted requests and returned acknowledgements within the current bus cycle and raises sticky fault flags on any protocol violation.

---
 rtl/fwb_slave_monitor_pkg.sv | 24 ++
 rtl/fwb_slave_monitor_if.sv | 27 ++
 rtl/fwb_timeout_ctr.sv | 36 +++
 rtl/fwb_slave_monitor.sv | 112 +++++++++++
 tb/tb_fwb_slave_monitor.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwb_slave_monitor_pkg.sv
// Shared definitions for the Wishbone B4 pipelined slave-side monitor.
//   - Fault bit positions inside o_fault_code.
//   - Default counter width and matching counter type.
//   - Limit-compare helper used by the consecutive-cycle timers.
package fwb_slave_monitor_pkg;

  localparam int unsigned F_LGDEPTH_DEF = 3;
  typedef logic [F_LGDEPTH_DEF-1:0] fcnt_t;

  localparam int unsigned FLT_STB_NO_CYC = 0;  // stb asserted outside a bus cycle
  localparam int unsigned FLT_STALL_HOLD = 1;  // stalled request not held stable
  localparam int unsigned FLT_ACK_ERR    = 2;  // ack and err in the same cycle
  localparam int unsigned FLT_SPURIOUS   = 3;  // response with nothing outstanding / no cyc
  localparam int unsigned FLT_STALL_TO   = 4;  // stall held too long
  localparam int unsigned FLT_ACK_TO     = 5;  // response took too long
  localparam int unsigned FLT_REQ_OVF    = 6;  // too many requests in one bus cycle
  localparam int unsigned FLT_DIR        = 7;  // mixed read/write while requests outstanding

  // A limit of zero disables the check.
  function automatic logic over_limit(input int unsigned cnt, input int unsigned lim);
    return (lim != 0) && (cnt > lim);
  endfunction

endpackage

// File: rtl/fwb_slave_monitor_if.sv
// Wishbone B4 pipelined bus bundle.
//   master  : drives cyc/stb/we/addr/data/sel, receives ack/stall/err/idata
//   slave   : the mirror image of master
//   monitor : passive observer, every signal is an input
interface fwb_slave_monitor_if #(
  parameter int AW = 15,
  parameter int DW = 32
) ();

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [DW/8-1:0] sel;
  logic          ack;
  logic          stall;
  logic          err;
  logic [DW-1:0] idata;

  modport master  (output cyc, stb, we, addr, data, sel,
                   input  ack, stall, err, idata);
  modport slave   (input  cyc, stb, we, addr, data, sel,
                   output ack, stall, err, idata);
  modport monitor (input  cyc, stb, we, addr, data, sel, ack, stall, err, idata);

endinterface

// File: rtl/fwb_timeout_ctr.sv
// Saturating consecutive-cycle counter with limit compare.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_inc          : condition holds this cycle (count), otherwise the count clears
//   o_over         : the count including this cycle exceeds LIMIT (LIMIT=0 disables)
module fwb_timeout_ctr
  import fwb_slave_monitor_pkg::*;
#(
  parameter int unsigned LIMIT = 6
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  output logic o_over
);

  // Wide enough to represent LIMIT+1, so saturation always sits above the limit.
  localparam int unsigned CW = $clog2(LIMIT + 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (i_inc) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Compare the count that includes the current sample so the violating
  // cycle itself is flagged and the sticky bit lands one clock later.
  assign o_over = over_limit(32'(cnt_d), LIMIT);

endmodule

// File: rtl/fwb_slave_monitor.sv
// Passive Wishbone B4 pipelined protocol monitor for the slave side.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   wb               : observed bus (monitor modport)
//   f_nreqs, f_nacks : requests accepted / responses returned in this bus cycle
//   f_outstanding    : f_nreqs - f_nacks
//   o_fault          : any sticky fault set
//   o_fault_code     : sticky per-rule fault flags (see package for bit map)
module fwb_slave_monitor
  import fwb_slave_monitor_pkg::*;
#(
  parameter int          AW              = 15,
  parameter int          DW              = 32,
  parameter int unsigned F_MAX_STALL     = 6,
  parameter int unsigned F_MAX_ACK_DELAY = 6,
  parameter int unsigned F_LGDEPTH       = F_LGDEPTH_DEF,
  parameter int unsigned F_MAX_REQUESTS  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  fwb_slave_monitor_if.monitor wb,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding,
  output logic                 o_fault,
  output logic [7:0]           o_fault_code
);

  logic accept, response, clear, full;
  logic stall_over, ack_over;
  logic rst_q;
  logic stalled_q, we_q, dir_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] sel_q;
  logic [7:0] viol;
  logic unused_idata;

  assign unused_idata  = ^wb.idata;
  assign accept        = wb.stb && !wb.stall;
  assign response      = wb.ack || wb.err;
  assign clear         = !wb.cyc || wb.err;
  assign f_outstanding = f_nreqs - f_nacks;
  assign full          = (f_nreqs == '1) ||
                         ((F_MAX_REQUESTS != 0) && (32'(f_nreqs) >= F_MAX_REQUESTS));

  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      f_nreqs <= '0;
      f_nacks <= '0;
    end else begin
      if (accept && !full)           f_nreqs <= f_nreqs + F_LGDEPTH'(1);
      if (response && f_nacks != '1) f_nacks <= f_nacks + F_LGDEPTH'(1);
    end
  end

  // Snapshot of the previous request, used to prove a stalled request was held.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stalled_q <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      stalled_q <= wb.cyc && wb.stb && wb.stall;
      if (accept) dir_q <= wb.we;
    end
    addr_q <= wb.addr;
    we_q   <= wb.we;
    data_q <= wb.data;
    sel_q  <= wb.sel;
  end

  fwb_timeout_ctr #(.LIMIT(F_MAX_STALL)) u_stall_ctr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (wb.stb && wb.stall),
    .o_over  (stall_over)
  );

  fwb_timeout_ctr #(.LIMIT(F_MAX_ACK_DELAY)) u_ack_ctr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (wb.cyc && (f_outstanding != '0) && !response),
    .o_over  (ack_over)
  );

  always_comb begin
    viol = '0;
    viol[FLT_STB_NO_CYC] = wb.stb && !wb.cyc;
    viol[FLT_STALL_HOLD] = stalled_q && wb.cyc &&
                           (!wb.stb || (wb.addr != addr_q) || (wb.we != we_q) ||
                            (we_q && ((wb.data != data_q) || (wb.sel != sel_q))));
    viol[FLT_ACK_ERR]    = wb.ack && wb.err;
    viol[FLT_SPURIOUS]   = response && ((f_outstanding == '0) || !wb.cyc);
    viol[FLT_STALL_TO]   = stall_over;
    viol[FLT_ACK_TO]     = ack_over;
    viol[FLT_REQ_OVF]    = wb.cyc && !wb.err && accept && full;
    viol[FLT_DIR]        = wb.cyc && wb.stb && (f_outstanding != '0) && (wb.we != dir_q);
  end

  // Checks are masked in the reset cycle and the one after it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rst_q        <= 1'b1;
      o_fault_code <= '0;
    end else begin
      rst_q <= 1'b0;
      if (!rst_q) o_fault_code <= o_fault_code | viol;
    end
  end

  assign o_fault = |o_fault_code;

endmodule

// File: tb/tb_fwb_slave_monitor.sv
// Self-checking bench for fwb_slave_monitor: directed protocol scenarios plus
// randomized traffic, all compared each cycle against a behavioural model.
module tb_fwb_slave_monitor;
  import fwb_slave_monitor_pkg::*;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MAX_STALL = 6;
  localparam int MAX_ACKD  = 6;
  localparam int MAX_REQ   = 2;
  localparam int CNT_TOP   = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fcnt_t f_nreqs, f_nacks, f_outstanding;
  logic o_fault;
  logic [7:0] o_fault_code;
  int n_vec = 0;
  int n_bad = 0;

  // Reference model state (plain integers, rules applied directly)
  int m_nreqs, m_nacks, m_stall_run, m_wait_run;
  logic [7:0] m_code;
  bit m_after_rst, m_stalled, m_dir;
  logic [AW+DW+SW:0] m_held;

  always #5 clk = ~clk;

  fwb_slave_monitor_if #(.AW(AW), .DW(DW)) wb ();

  fwb_slave_monitor #(
    .AW(AW), .DW(DW), .F_MAX_STALL(MAX_STALL), .F_MAX_ACK_DELAY(MAX_ACKD),
    .F_LGDEPTH(3), .F_MAX_REQUESTS(MAX_REQ)
  ) dut (
    .i_clk(clk), .i_reset(rst), .wb(wb),
    .f_nreqs(f_nreqs), .f_nacks(f_nacks), .f_outstanding(f_outstanding),
    .o_fault(o_fault), .o_fault_code(o_fault_code)
  );

  // Identity of a request: data/sel only matter for writes.
  function automatic logic [AW+DW+SW:0] req_key(input logic [AW-1:0] a, input logic w,
                                                input logic [DW-1:0] d, input logic [SW-1:0] s);
    return {a, w, (w ? {d, s} : {(DW+SW){1'b0}})};
  endfunction

  task automatic drive(input bit cyc, input bit stb, input bit stall, input bit ack, input bit err);
    wb.cyc = cyc; wb.stb = stb; wb.stall = stall; wb.ack = ack; wb.err = err;
  endtask

  // Advance the model over the current inputs, then clock the DUT.
  task automatic tick();
    bit acc, rsp, full;
    int outs;
    logic [7:0] v;
    acc  = wb.stb && !wb.stall;
    rsp  = wb.ack || wb.err;
    outs = int'(fcnt_t'(m_nreqs - m_nacks));
    full = (m_nreqs >= MAX_REQ) || (m_nreqs >= CNT_TOP);
    m_stall_run = (wb.stb && wb.stall) ? m_stall_run + 1 : 0;
    m_wait_run  = (wb.cyc && outs != 0 && !rsp) ? m_wait_run + 1 : 0;
    v = '0;
    v[0] = wb.stb && !wb.cyc;
    v[1] = m_stalled && wb.cyc && (!wb.stb || req_key(wb.addr, wb.we, wb.data, wb.sel) != m_held);
    v[2] = wb.ack && wb.err;
    v[3] = rsp && (outs == 0 || !wb.cyc);
    v[4] = m_stall_run > MAX_STALL;
    v[5] = m_wait_run > MAX_ACKD;
    v[6] = wb.cyc && !wb.err && acc && full;
    v[7] = wb.cyc && wb.stb && outs != 0 && wb.we != m_dir;
    if (rst) begin
      m_nreqs = 0; m_nacks = 0; m_stall_run = 0; m_wait_run = 0;
      m_code = '0; m_after_rst = 1; m_stalled = 0; m_dir = 0;
    end else begin
      if (!m_after_rst) m_code |= v;
      m_after_rst = 0;
      if (!wb.cyc || wb.err) begin
        m_nreqs = 0; m_nacks = 0;
      end else begin
        if (acc && !full) m_nreqs++;
        if (rsp && m_nacks < CNT_TOP) m_nacks++;
      end
      m_stalled = wb.cyc && wb.stb && wb.stall;
      m_held = req_key(wb.addr, wb.we, wb.data, wb.sel);
      if (acc) m_dir = wb.we;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 1, 1, 1);
    wb.we = 1'b1; wb.addr = AW'($urandom); wb.data = $urandom; wb.sel = SW'($urandom);
    tick();
    n_vec++;
    if ({f_nreqs, f_nacks, f_outstanding} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", f_nreqs, f_nacks, f_outstanding);
    end
    n_vec++;
    if ({o_fault, o_fault_code} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_faults: got fault=%0b code=%02h want 0 00", o_fault, o_fault_code);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    n_vec++;
    if ({f_nreqs, f_nacks, f_outstanding, o_fault, o_fault_code} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %0d/%0d/%0d code=%02h want all zero", f_nreqs, f_nacks, f_outstanding, o_fault_code);
    end
  endtask

  task automatic test_single_write();
    int s, d;
    s = $urandom_range(0, 6);
    d = $urandom_range(1, 6);
    wb.we = 1'b1; wb.addr = AW'($urandom); wb.data = $urandom; wb.sel = SW'($urandom);
    for (int t = 0; t <= s + d + 2; t++) begin
      drive(t <= s + d, t <= s, t < s, t == s + d, 0);
      tick();
      n_vec++;
      if ({f_nreqs, f_nacks, f_outstanding} !== {fcnt_t'(m_nreqs), fcnt_t'(m_nacks), fcnt_t'(m_nreqs - m_nacks)}) begin
        n_bad++;
        $display("FAIL single_write_counters t=%0d: got %0d/%0d/%0d want %0d/%0d", t, f_nreqs, f_nacks, f_outstanding, m_nreqs, m_nacks);
      end
      n_vec++;
      if ({o_fault, o_fault_code} !== {m_code != 0, m_code}) begin
        n_bad++;
        $display("FAIL single_write_faults t=%0d: got %02h want %02h", t, o_fault_code, m_code);
      end
      if (t == s + d) begin
        n_vec++;
        if (f_nreqs !== 3'd1 || f_nacks !== 3'd1 || o_fault_code !== 8'h00) begin
          n_bad++;
          $display("FAIL single_write_ack: got %0d/%0d code=%02h want 1/1 00", f_nreqs, f_nacks, o_fault_code);
        end
      end
    end
    n_vec++;
    if (f_nreqs !== 3'd0 || f_nacks !== 3'd0) begin
      n_bad++;
      $display("FAIL single_write_clear: got %0d/%0d want 0/0", f_nreqs, f_nacks);
    end
  endtask

  task automatic test_pipelined_reads();
    int a1, peak;
    a1 = 2 + $urandom_range(1, 3);
    peak = 0;
    wb.we = 1'b0; wb.addr = AW'($urandom); wb.data = $urandom; wb.sel = '1;
    for (int t = 0; t <= a1 + 2; t++) begin
      drive(t <= a1, t <= 1, 0, t == 2 || t == a1, 0);
      if (t == 1) wb.addr = wb.addr + AW'(4);
      tick();
      if (int'(f_outstanding) > peak) peak = int'(f_outstanding);
      n_vec++;
      if ({f_nreqs, f_nacks, f_outstanding} !== {fcnt_t'(m_nreqs), fcnt_t'(m_nacks), fcnt_t'(m_nreqs - m_nacks)}) begin
        n_bad++;
        $display("FAIL pipelined_counters t=%0d: got %0d/%0d/%0d want %0d/%0d", t, f_nreqs, f_nacks, f_outstanding, m_nreqs, m_nacks);
      end
      n_vec++;
      if ({o_fault, o_fault_code} !== {m_code != 0, m_code}) begin
        n_bad++;
        $display("FAIL pipelined_faults t=%0d: got %02h want %02h", t, o_fault_code, m_code);
      end
    end
    n_vec++;
    if (peak != 2 || f_outstanding !== 3'd0 || o_fault_code !== 8'h00) begin
      n_bad++;
      $display("FAIL pipelined_summary: got peak=%0d outs=%0d code=%02h want 2 0 00", peak, f_outstanding, o_fault_code);
    end
  endtask

  task automatic test_stall_timeout();
    do_reset();
    wb.we = 1'b0; wb.addr = AW'($urandom); wb.data = $urandom; wb.sel = '1;
    for (int t = 0; t <= 10; t++) begin
      drive(t <= 8, t <= 7, t <= 6, t == 8, 0);
      tick();
      n_vec++;
      if ({o_fault, o_fault_code} !== {m_code != 0, m_code}) begin
        n_bad++;
        $display("FAIL stall_timeout_faults t=%0d: got %02h want %02h", t, o_fault_code, m_code);
      end
      if (t == 5 || t == 6 || t == 10) begin
        n_vec++;
        if (o_fault_code !== ((t == 5) ? 8'h00 : 8'h10) || o_fault !== (t != 5)) begin
          n_bad++;
          $display("FAIL stall_timeout_bit4 t=%0d: got fault=%0b code=%02h", t, o_fault, o_fault_code);
        end
      end
    end
    do_reset();
    n_vec++;
    if ({o_fault, o_fault_code} !== 9'd0) begin
      n_bad++;
      $display("FAIL stall_timeout_reset: got %02h want 00", o_fault_code);
    end
  endtask

  task automatic test_bad_responses();
    do_reset();
    for (int t = 0; t <= 2; t++) begin
      drive(t <= 1, 0, 0, t == 0, 0);
      tick();
      n_vec++;
      if ({o_fault_code, f_outstanding} !== {m_code, fcnt_t'(m_nreqs - m_nacks)}) begin
        n_bad++;
        $display("FAIL spurious_ack t=%0d: got code=%02h outs=%0d want %02h", t, o_fault_code, f_outstanding, m_code);
      end
      if (t == 0) begin
        n_vec++;
        if (o_fault_code !== 8'h08) begin
          n_bad++;
          $display("FAIL spurious_ack_bit3: got %02h want 08", o_fault_code);
        end
      end
    end
    do_reset();
    wb.we = 1'b0;
    for (int t = 0; t <= 2; t++) begin
      drive(t <= 1, t == 0, 0, t == 1, t == 1);
      tick();
      n_vec++;
      if ({o_fault_code, f_nreqs, f_nacks} !== {m_code, fcnt_t'(m_nreqs), fcnt_t'(m_nacks)}) begin
        n_bad++;
        $display("FAIL ack_err t=%0d: got code=%02h %0d/%0d want %02h %0d/%0d", t, o_fault_code, f_nreqs, f_nacks, m_code, m_nreqs, m_nacks);
      end
      if (t == 1) begin
        n_vec++;
        if (o_fault_code !== 8'h04 || f_nreqs !== 3'd0) begin
          n_bad++;
          $display("FAIL ack_err_bit2: got code=%02h nreqs=%0d want 04 0", o_fault_code, f_nreqs);
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    wb.we = 1'b0; wb.addr = AW'($urandom);
    for (int t = 0; t <= 2; t++) begin
      drive(t <= 1, t <= 1, t <= 1, 0, 0);
      if (t == 1) wb.addr = wb.addr ^ AW'(1);
      tick();
      n_vec++;
      if ({o_fault, o_fault_code} !== {m_code != 0, m_code}) begin
        n_bad++;
        $display("FAIL stall_hold t=%0d: got %02h want %02h", t, o_fault_code, m_code);
      end
    end
    n_vec++;
    if (o_fault_code !== 8'h02) begin
      n_bad++;
      $display("FAIL stall_hold_bit1: got %02h want 02", o_fault_code);
    end
    do_reset();
    drive(0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if ({o_fault, o_fault_code} !== {1'b1, 8'h01} || m_code !== 8'h01) begin
      n_bad++;
      $display("FAIL stb_no_cyc: got %02h want 01", o_fault_code);
    end
    tick();
  endtask

  task automatic test_too_many();
    do_reset();
    wb.we = 1'b1; wb.data = $urandom; wb.sel = '1;
    for (int t = 0; t <= 2; t++) begin
      drive(1, 1, 0, 0, 0);
      wb.addr = AW'($urandom);
      tick();
      n_vec++;
      if ({f_nreqs, o_fault_code} !== {fcnt_t'(m_nreqs), m_code}) begin
        n_bad++;
        $display("FAIL too_many t=%0d: got nreqs=%0d code=%02h want %0d %02h", t, f_nreqs, o_fault_code, m_nreqs, m_code);
      end
    end
    n_vec++;
    if (f_nreqs !== 3'd2 || o_fault_code !== 8'h40) begin
      n_bad++;
      $display("FAIL too_many_bit6: got nreqs=%0d code=%02h want 2 40", f_nreqs, o_fault_code);
    end
    rst = 1'b1;
    drive(1, 1, 0, 0, 0);
    tick();
    n_vec++;
    if ({f_nreqs, f_nacks, f_outstanding, o_fault, o_fault_code} !== 18'd0) begin
      n_bad++;
      $display("FAIL midcycle_reset: got %0d/%0d/%0d code=%02h want all zero", f_nreqs, f_nacks, f_outstanding, o_fault_code);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (m_stalled && $urandom_range(0, 7) != 0) begin
        wb.cyc = 1'b1; wb.stb = 1'b1;
      end else begin
        if ($urandom_range(0, 7) == 0) wb.cyc = !wb.cyc;
        wb.stb  = wb.cyc ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
        wb.we   = ($urandom_range(0, 5) == 0) ? !wb.we : wb.we;
        wb.addr = AW'($urandom);
        wb.data = $urandom;
        wb.sel  = SW'($urandom);
      end
      wb.stall = ($urandom_range(0, 2) == 0);
      wb.ack   = ($urandom_range(0, 2) == 0);
      wb.err   = ($urandom_range(0, 29) == 0);
      tick();
      n_vec++;
      if ({f_nreqs, f_nacks, f_outstanding} !== {fcnt_t'(m_nreqs), fcnt_t'(m_nacks), fcnt_t'(m_nreqs - m_nacks)}) begin
        n_bad++;
        $display("FAIL random_counters t=%0d: got %0d/%0d/%0d want %0d/%0d", t, f_nreqs, f_nacks, f_outstanding, m_nreqs, m_nacks);
      end
      n_vec++;
      if ({o_fault, o_fault_code} !== {m_code != 0, m_code}) begin
        n_bad++;
        $display("FAIL random_faults t=%0d: got %02h want %02h", t, o_fault_code, m_code);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    wb.we = 1'b0; wb.addr = '0; wb.data = '0; wb.sel = '0; wb.idata = '0;
    m_nreqs = 0; m_nacks = 0; m_stall_run = 0; m_wait_run = 0;
    m_code = '0; m_after_rst = 1; m_stalled = 0; m_dir = 0; m_held = '0;
    test_reset();
    test_single_write();
    test_single_write();
    test_pipelined_reads();
    test_stall_timeout();
    test_bad_responses();
    test_stall_hold();
    test_too_many();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
